delay_line_prog: RTL

Runtime-programmable, valid-tagged delay line. It is the successor to the fixed-latency delay pipeline used across the map-inflation datapath. Latency is selectable per run from 0 to MAX_LATENCY without re-synthesis, with a stall enable, flush-on-reprogram and a fill indicator. It sits between producer and consumer stages whose relative alignment depends on runtime configuration, for example kernel radius.

---
 rtl/delay_line_prog.sv | 126 ++++++++++++
 1 files changed

// File: rtl/delay_line_prog.sv
// Runtime-programmable, valid-tagged delay line.
// A fixed chain of MAX_LATENCY {valid, data} stages shifts on every enabled edge; the
// output tap is picked by the latency in force, with a combinational bypass at latency 0.
// Loading a new latency flushes in-flight samples so that nothing from the old alignment
// ever reaches the consumer.
module delay_line_prog #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned MAX_LATENCY   = 16,
   parameter int unsigned LAT_W         = 5,
   parameter int unsigned RESET_LATENCY = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             lat_load_i,
   input  logic [LAT_W-1:0] lat_in_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic [LAT_W-1:0] lat_cur_o,
   output logic             primed_o,
   output logic             lat_err_o
);

   localparam logic [LAT_W:0]   MaxLatExt = (LAT_W+1)'(MAX_LATENCY);
   localparam logic [LAT_W-1:0] MaxLat    = LAT_W'(MAX_LATENCY);
   localparam logic [LAT_W-1:0] ResetLat  = LAT_W'(RESET_LATENCY);

   logic [MAX_LATENCY-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]       data_q [MAX_LATENCY];
   logic [WIDTH-1:0]       data_d [MAX_LATENCY];
   logic [LAT_W-1:0]       lat_cur_q, lat_cur_d;
   logic [LAT_W:0]         fill_cnt_q, fill_cnt_d;
   logic                   lat_err_q, lat_err_d;

   logic                   tap_valid;
   logic [WIDTH-1:0]       tap_data;
   logic                   byp_valid;

   // Next state: shift on enable, then apply a latency load (flush) on top of it.
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      lat_cur_d  = lat_cur_q;
      fill_cnt_d = fill_cnt_q;
      lat_err_d  = lat_err_q;

      if (en_i) begin
         valid_d[0] = in_valid_i;
         data_d[0]  = in_data_i;
         for (int i = 1; i < MAX_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
         if (fill_cnt_q < MaxLatExt) begin
            fill_cnt_d = fill_cnt_q + (LAT_W+1)'(1);
         end
      end

      if (lat_load_i) begin
         if ({1'b0, lat_in_i} > MaxLatExt) begin
            lat_cur_d = MaxLat;
            lat_err_d = 1'b1;
         end else begin
            lat_cur_d = lat_in_i;
            lat_err_d = 1'b0;
         end
         // Data bits are left stale; the output mask hides them.
         for (int i = 1; i < MAX_LATENCY; i++) begin
            valid_d[i] = 1'b0;
         end
         // With en=1 stage 0 holds the first sample under the new latency.
         if (!en_i) begin
            valid_d[0] = 1'b0;
         end
         fill_cnt_d = {{LAT_W{1'b0}}, en_i};
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < MAX_LATENCY; i++) begin
            data_q[i] <= '0;
         end
         lat_cur_q  <= ResetLat;
         fill_cnt_q <= '0;
         lat_err_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < MAX_LATENCY; i++) begin
            data_q[i] <= data_d[i];
         end
         lat_cur_q  <= lat_cur_d;
         fill_cnt_q <= fill_cnt_d;
         lat_err_q  <= lat_err_d;
      end
   end

   // Output tap: stage lat_cur-1, or the live input when latency is 0.
   always_comb begin
      tap_valid = 1'b0;
      tap_data  = '0;
      for (int i = 0; i < MAX_LATENCY; i++) begin
         if (lat_cur_q == LAT_W'(i + 1)) begin
            tap_valid = valid_q[i];
            tap_data  = data_q[i];
         end
      end
      byp_valid = in_valid_i & en_i;
      if (lat_cur_q == '0) begin
         out_valid_o = byp_valid;
         out_data_o  = byp_valid ? in_data_i : '0;
      end else begin
         out_valid_o = tap_valid;
         out_data_o  = tap_valid ? tap_data : '0;
      end
   end

   assign lat_cur_o = lat_cur_q;
   assign lat_err_o = lat_err_q;
   assign primed_o  = (fill_cnt_q >= {1'b0, lat_cur_q});

endmodule
